// File: rtl/uart_echo.sv
// uart_echo: UART loopback endpoint.
// An oversampling receiver feeds a one-entry holding register, and a
// transmitter re-sends every received word unchanged. All logic runs on clk_i.
// Frame format: start bit (0), DataWidth data bits LSB first, stop bit (1).
// One bit lasts Prescale*8 clock cycles. Prescale = 0 behaves like 1.
//
// Optional build macro: UART_ECHO_FRAME_CHECK_EN
//   defined   : a frame whose stop sample is 0 is discarded.
//   undefined : the word is kept whatever the stop sample is. A held-low line
//               (break) still produces only one word, because the receiver
//               waits for the line to return high before it re-arms.
//
// Handshake between the receiver and the holding register, and between the
// holding register and the transmitter (valid/ready):
//   w_rx_write is a one-cycle valid pulse carrying r_rx_shift. The holding
//   register is "ready" when it is empty, or when it is popped in the same
//   cycle. A write arriving while it is full and not being popped is dropped,
//   and the stored word is kept. r_hold_full is the valid flag toward the
//   transmitter. w_tx_pop is its ready/accept pulse, raised in the cycle the
//   transmitter commits to a new frame.
module uart_echo #(
  parameter int          DataWidth = 8,
  parameter logic [15:0] Prescale  = 16'd1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rx_data_i,
  output logic tx_data_o
);

  localparam logic [15:0] PrescaleEff = (Prescale == 16'd0) ? 16'd1 : Prescale;
  // 19 bits hold Prescale*8 without overflow, even at Prescale = 16'hFFFF.
  localparam logic [18:0] BitCycles  = {PrescaleEff, 3'b000};
  localparam logic [18:0] HalfCycles = {1'b0, PrescaleEff, 2'b00};
  localparam logic [18:0] CntOne     = 19'd1;
  localparam int          BitIdxW    = $clog2(DataWidth + 1);
  localparam logic [BitIdxW-1:0] LastBit = BitIdxW'(DataWidth - 1);
  localparam logic [BitIdxW-1:0] BitOne  = BitIdxW'(1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Receive-side state
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  rx_state_t            r_rx_state;
  rx_state_t            w_rx_state_nxt;
  logic [18:0]          r_rx_cnt;
  logic [18:0]          w_rx_cnt_nxt;
  logic [BitIdxW-1:0]   r_rx_bit;
  logic [BitIdxW-1:0]   w_rx_bit_nxt;
  logic [DataWidth-1:0] r_rx_shift;
  logic [DataWidth-1:0] w_rx_shift_nxt;
  logic                 w_rx_write;

  // One-entry holding register
  logic                 r_hold_full;
  logic [DataWidth-1:0] r_hold_data;

  // Transmit-side state
  tx_state_t            r_tx_state;
  tx_state_t            w_tx_state_nxt;
  logic [18:0]          r_tx_cnt;
  logic [18:0]          w_tx_cnt_nxt;
  logic [BitIdxW-1:0]   r_tx_bit;
  logic [BitIdxW-1:0]   w_tx_bit_nxt;
  logic [DataWidth-1:0] r_tx_shift;
  logic [DataWidth-1:0] w_tx_shift_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_tx_pop;

  // Two-flop synchronizer for the asynchronous serial input. Both flops reset
  // to the idle-high line level.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_data_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state, counter and shift register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  // Receiver next state. The start bit is checked half a bit after the
  // falling edge; every later sample is one full bit apart, so each one lands
  // in the middle of its bit.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_write     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = HalfCycles - CntOne;
        end
      end
      RX_START: begin
        if (r_rx_cnt != '0) begin
          w_rx_cnt_nxt = r_rx_cnt - CntOne;
        end else if (!r_rx_sync) begin
          w_rx_state_nxt = RX_DATA;
          w_rx_cnt_nxt   = BitCycles - CntOne;
          w_rx_bit_nxt   = '0;
        end else begin
          // The line went high again before mid-start, so this was a glitch.
          w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt != '0) begin
          w_rx_cnt_nxt = r_rx_cnt - CntOne;
        end else begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DataWidth-1:1]};
          w_rx_cnt_nxt   = BitCycles - CntOne;
          if (r_rx_bit == LastBit) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + BitOne;
          end
        end
      end
      RX_STOP: begin
        if (r_rx_cnt != '0) begin
          w_rx_cnt_nxt = r_rx_cnt - CntOne;
        end else if (r_rx_sync) begin
          w_rx_write     = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end else begin
`ifdef UART_ECHO_FRAME_CHECK_EN
          w_rx_write = 1'b0;
`else
          w_rx_write = 1'b1;
`endif
          w_rx_state_nxt = RX_WAIT_IDLE;
        end
      end
      RX_WAIT_IDLE: begin
        if (r_rx_sync) begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: begin
        w_rx_state_nxt = RX_IDLE;
      end
    endcase
  end

  // Holding register. When a write and a pop happen in the same cycle, the
  // new word replaces the one being popped.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_tx_pop) begin
      r_hold_full <= w_rx_write;
      if (w_rx_write) begin
        r_hold_data <= r_rx_shift;
      end
    end else if (w_rx_write && !r_hold_full) begin
      r_hold_full <= 1'b1;
      r_hold_data <= r_rx_shift;
    end
  end

  // Transmitter state, counter, shift register and the output flop.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // Transmitter next state. The line level for the next cycle is computed
  // here and registered, so the output is glitch-free. At the end of a stop
  // bit the transmitter goes straight to the next start bit if a word is
  // waiting, which keeps frames back to back with no idle cycle between them.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_nxt       = r_tx;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (r_hold_full) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = BitCycles - CntOne;
          w_tx_shift_nxt = r_hold_data;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_START: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - CntOne;
        end else begin
          w_tx_state_nxt = TX_DATA;
          w_tx_cnt_nxt   = BitCycles - CntOne;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = r_tx_shift[0];
        end
      end
      TX_DATA: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - CntOne;
        end else begin
          w_tx_cnt_nxt = BitCycles - CntOne;
          if (r_tx_bit == LastBit) begin
            w_tx_state_nxt = TX_STOP;
            w_tx_nxt       = 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + BitOne;
            w_tx_shift_nxt = {1'b0, r_tx_shift[DataWidth-1:1]};
            w_tx_nxt       = r_tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt_nxt = r_tx_cnt - CntOne;
        end else if (r_hold_full) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_START;
          w_tx_cnt_nxt   = BitCycles - CntOne;
          w_tx_shift_nxt = r_hold_data;
          w_tx_nxt       = 1'b0;
        end else begin
          w_tx_state_nxt = TX_IDLE;
          w_tx_nxt       = 1'b1;
        end
      end
      default: begin
        w_tx_state_nxt = TX_IDLE;
        w_tx_nxt       = 1'b1;
      end
    endcase
  end

  assign tx_data_o = r_tx;

endmodule

// File: tb/tb_uart_echo.sv
// Testbench for uart_echo. There are three instances (Prescale 1, 4 and 2)
// sharing one clock and one reset. Each instance has its own serial line in
// each direction.
module tb_uart_echo;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [2:0] rx_bus;
  wire  [2:0] tx_bus;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int stop_cyc;
  int mon_start_cyc;

  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  uart_echo #(.DataWidth(8), .Prescale(16'd1)) u_dut_p1 (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_bus[0]), .tx_data_o(tx_bus[0]));
  uart_echo #(.DataWidth(8), .Prescale(16'd4)) u_dut_p4 (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_bus[1]), .tx_data_o(tx_bus[1]));
  uart_echo #(.DataWidth(8), .Prescale(16'd2)) u_dut_p2 (
    .clk_i(clk), .reset_i(reset_i), .rx_data_i(rx_bus[2]), .tx_data_o(tx_bus[2]));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sends one frame on line inst. The task starts and ends on a negedge.
  task automatic send_frame(input int inst, input logic [7:0] data,
                            input logic stop_bit, input int bitc);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_bus[inst] = fr[b];
      if (b == 9) stop_cyc = cyc;
      repeat (bitc) @(negedge clk);
    end
    rx_bus[inst] = 1'b1;
  endtask

  // Waits for a start bit on tx line inst, then scores each of the 10 bit
  // windows. A bit counts as correct when at least thresh of its cycles match.
  task automatic mon_frame(input int inst, input int bitc, input int thresh,
                           input logic [7:0] data, input string tag);
    int t;
    int good;
    logic [9:0] exp_fr;
    logic [9:0] obs;
    t = 0;
    while (tx_bus[inst] !== 1'b0 && t < 14 * bitc + 40) begin
      @(negedge clk);
      t++;
    end
    if (tx_bus[inst] !== 1'b0) begin
      check({tag, "_start"}, {31'b0, tx_bus[inst]}, 32'd0);
      return;
    end
    mon_start_cyc = cyc;
    exp_fr = {1'b1, data, 1'b0};
    obs = '0;
    for (int b = 0; b < 10; b++) begin
      good = 0;
      for (int i = 0; i < bitc; i++) begin
        if (tx_bus[inst] === exp_fr[b]) good++;
        @(negedge clk);
      end
      obs[b] = (good >= thresh) ? exp_fr[b] : ~exp_fr[b];
    end
    check(tag, {22'b0, obs}, {22'b0, exp_fr});
  endtask

  // ---------------- stimulus ----------------
  int lows;
  int lat;
  int exp_low;

  initial begin
    reset_i = 1'b1;
    rx_bus  = 3'b111;
    #2 reset_i = 1'b0;

    // Reset, and idle afterwards
    @(negedge clk);
    check("reset_tx_c0", {29'b0, tx_bus}, 32'h7);
    @(negedge clk);
    check("reset_tx_c1", {29'b0, tx_bus}, 32'h7);
    reset_i = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx", {29'b0, tx_bus}, 32'h7);

    // Prescale=1: all 256 values, sent back to back
    fork
      begin
        for (int v = 0; v < 256; v++) begin
          exp_q.push_back(v[7:0]);
          send_frame(0, v[7:0], 1'b1, 8);
        end
      end
      begin
        for (int k = 0; k < 256; k++) begin
          logic [7:0] e;
          wait (exp_q.size() != 0);
          e = exp_q.pop_front();
          mon_frame(0, 8, 4, e, $sformatf("echo_%02h", e));
        end
      end
    join
    repeat (20) @(negedge clk);

    // Prescale=4: 0xA5, exact bit timing and bounded latency
    fork
      send_frame(1, 8'hA5, 1'b1, 32);
      mon_frame(1, 32, 32, 8'hA5, "a5_frame");
    join
    lat = mon_start_cyc - stop_cyc;
    check("a5_latency_in_bound", {31'b0, (lat > 0 && lat <= 16 + 5)}, 32'd1);
    repeat (10) @(negedge clk);

    // Prescale=2: a 2-cycle low pulse must not start a frame
    rx_bus[2] = 1'b0;
    repeat (2) @(negedge clk);
    rx_bus[2] = 1'b1;
    lows = 0;
    repeat (200) begin
      if (tx_bus[2] === 1'b0) lows++;
      @(negedge clk);
    end
    check("glitch_tx_low_cycles", lows, 32'd0);
    fork
      send_frame(2, 8'h96, 1'b1, 16);
      mon_frame(2, 16, 8, 8'h96, "p2_after_glitch");
    join
    repeat (10) @(negedge clk);

    // Prescale=1: 0x3C with the stop bit forced low. An echo of 0x3C holds
    // the line low for 5 bits (start + four zero data bits) = 40 cycles.
`ifdef UART_ECHO_FRAME_CHECK_EN
    exp_low = 0;
`else
    exp_low = 40;
`endif
    fork
      send_frame(0, 8'h3C, 1'b0, 8);
      begin
        lows = 0;
        repeat (300) begin
          if (tx_bus[0] === 1'b0) lows++;
          @(negedge clk);
        end
      end
    join
    check("bad_stop_low_cycles", lows, exp_low);

    // Reset in the middle of data bit 2 (a 0) of a 0x5A echo
    send_frame(0, 8'h5A, 1'b1, 8);
    begin
      int t;
      t = 0;
      while (tx_bus[0] !== 1'b0 && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    repeat (3 * 8 + 3) @(negedge clk);
    check("pre_reset_tx_bit2", {31'b0, tx_bus[0]}, 32'd0);
    reset_i = 1'b0;
    #1;
    check("reset_tx_immediate", {29'b0, tx_bus}, 32'h7);
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    repeat (5) @(negedge clk);
    fork
      send_frame(0, 8'h5A, 1'b1, 8);
      mon_frame(0, 8, 4, 8'h5A, "post_reset_5a");
    join
    repeat (10) @(negedge clk);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_echo.md
Name: uart_echo

Overview:
- UART loopback block: receives 8N1-style serial frames on rx_data_i and retransmits each correctly received data word on tx_data_o, unchanged.
- Contains an oversampling UART receiver, a 1-entry holding register and a UART transmitter, all on one clock.
- Used as the bring-up and link-check endpoint for the UART/ALU datapath.

Parameters:
- DataWidth, 8, data bits per frame, sent and received LSB first.
- Prescale, 16'd1, 16-bit baud divider. One bit period = Prescale*8 clk_i cycles. Prescale=0 is treated as 1.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- rx_data_i  input  1  serial receive line; idle high; asynchronous to clk_i.
- tx_data_o  output  1  serial transmit line; idle high.

Behaviour:
- Frame format: 1 start bit (0), DataWidth data bits LSB first, 1 stop bit (1), no parity. Each bit lasts BIT = Prescale*8 cycles.
- Reset values:
  - tx_data_o = 1.
  - RX and TX FSMs = IDLE; counters = 0; holding register empty.
  - rx synchronizer flops = 1.
- RX input path: rx_data_i passes through a 2-flop synchronizer. All RX decisions use the synchronized value.
- RX FSM states and transitions:
  - IDLE: on synchronized 0, go to START and load the counter.
  - START: wait BIT/2 cycles, then resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE.
  - DATA: sample once every BIT cycles, at mid-bit. Shift in LSB first, DataWidth samples, then go to STOP.
  - STOP: wait BIT cycles and sample at mid-stop. If 1, the frame is valid: write the word to the holding register, then go to IDLE. If 0, apply the framing rule (see Optional Feature), then go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is sampled 1, then go to IDLE.
- Holding register: 1 entry.
  - A write while the entry is full is dropped (newest lost); the stored word is kept.
  - The TX FSM pops the entry in the cycle it leaves IDLE.
  - A write and a pop in the same cycle is legal; the new word is stored.
- TX FSM:
  - IDLE: tx_data_o = 1. When the holding register is full, go to START in the next cycle.
  - START: tx_data_o = 0 for BIT cycles.
  - DATA: DataWidth bits, LSB first, BIT cycles each.
  - STOP: tx_data_o = 1 for BIT cycles, then IDLE.
- tx_data_o is driven from a flop, so it is glitch-free.
- Latency: first TX start-bit edge occurs at most 3 cycles after the RX mid-stop sample. This is about BIT/2+5 cycles after the stop-bit edge on rx_data_i. The echoed frame therefore overlaps the next bit window by less than half a bit, so each TX bit is correct for more than half of the BIT-cycle window that immediately follows the received frame.
- Back-to-back frames:
  - RX accepts a new start bit immediately after the mid-stop sample.
  - TX sends frames back to back without extra idle time when the holding register is refilled.
- Counters: bit counter wide enough for Prescale*8 (19 bits); no overflow at Prescale = 16'hFFFF.
- Reset mid-frame: both FSMs return to IDLE at once, tx_data_o = 1 at once, and any partial or held word is discarded.

Optional Feature:
- Macro UART_ECHO_FRAME_CHECK_EN.
- Defined: a frame whose stop sample is 0 is discarded and not echoed.
- Undefined: the received word is written to the holding register regardless of the stop sample. RX still passes through WAIT_IDLE, so a continuous low line (break) yields one word, not repeated words.

Test Plan:
- Reset with reset_i=0 for 2 cycles, rx_data_i=1 -> tx_data_o=1 throughout reset and while idle.
- Prescale=1, send 0x00..0xFF sequentially, each followed by checking its echo -> each echoed bit correct in at least 4 of its 8 sampled cycles, for all 256 values.
- Prescale=4, send 0xA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit for 32 cycles, echo starting within BIT/2+5 cycles of the rx stop edge.
- 2-cycle low pulse on rx_data_i in IDLE (Prescale=2) -> no TX activity; tx_data_o stays 1.
- Send 0x3C with stop bit forced 0 -> with UART_ECHO_FRAME_CHECK_EN no echo; without it 0x3C is echoed once.
- Assert reset_i low in the middle of a TX data bit -> tx_data_o=1 immediately; after release, next frame 0x5A echoes correctly.
